// File: rtl/square_judge_pkg.sv
// Shared state encodings, default constants and the vote helper for the
// square-wave judge sequencer.
package square_judge_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int DEF_WIDTH_W    = 18;
    localparam int DEF_VOTE_NUM   = 5;
    localparam int DEF_GAP_CYCLES = 16;
    localparam int DEF_TIMEOUT    = 6016;
    localparam int DEF_CNT_W      = 32;

    // Strict majority: 2*votes > vote_num, evaluated on 6 bits so it cannot wrap.
    function automatic logic majority(input logic [3:0] votes, input logic [3:0] vote_num);
        return ({1'b0, votes, 1'b0} > {2'b00, vote_num});
    endfunction

endpackage

// File: rtl/square_judge_sched_cycle_timer.sv
// Saturating up-counter with synchronous clear and terminal-count flag,
// reused for the inter-window gap and the judge response timeout.
module cycle_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Counter: clear has priority, then count up and hold at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r < limit)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == limit);

endmodule

// File: rtl/square_judge_sched.sv
// Runs VOTE_NUM judge windows per request and reports the majority decision,
// the minimum width over square windows and a response timeout.
module square_judge_sched
    import square_judge_pkg::*;
#(
    parameter int WIDTH_W    = DEF_WIDTH_W,
    parameter int VOTE_NUM   = DEF_VOTE_NUM,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               abort,
    output logic               busy,
    output logic               judge_start,
    input  logic               judge_dready,
    input  logic               judge_is_square,
    input  logic [WIDTH_W-1:0] judge_min_width,
    output logic               result_valid,
    output logic               result_square,
    output logic [WIDTH_W-1:0] result_min_width,
    output logic [3:0]         result_votes,
    output logic               err_timeout
);

    localparam logic [3:0]         VOTE_NUM_C = 4'(VOTE_NUM);
    localparam logic [CNT_W-1:0]   TO_LIMIT   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   GAP_LIMIT  = CNT_W'(GAP_CYCLES);
    localparam logic [WIDTH_W-1:0] MIN_INIT   = {WIDTH_W{1'b1}};

    logic [2:0]         state_r, fsm_next_s, state_next_s;
    logic [3:0]         win_cnt_r, win_next_s;
    logic [3:0]         vote_cnt_r, vote_next_s;
    logic [WIDTH_W-1:0] min_r, min_next_s;
    logic               to_flag_r, to_next_s;

    logic               timer_clear_s, timer_en_s, timer_term_s;
    logic [CNT_W-1:0]   timer_limit_s;

    logic               busy_r, judge_start_r, result_valid_r, result_square_r, err_timeout_r;
    logic [WIDTH_W-1:0] result_min_width_r;
    logic [3:0]         result_votes_r;

    // The timer restarts from zero on every state change, so the first cycle of
    // WAIT or GAP always sees count 0.
    always_comb begin
        timer_clear_s = (state_next_s != state_r);
        timer_en_s    = (state_r == ST_WAIT) || (state_r == ST_GAP);
        timer_limit_s = (state_r == ST_GAP) ? GAP_LIMIT : TO_LIMIT;
    end

    cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear_s),
        .enable   (timer_en_s),
        .limit    (timer_limit_s),
        .terminal (timer_term_s)
    );

    // Next-state and window bookkeeping; dready beats timeout in WAIT.
    always_comb begin
        fsm_next_s  = state_r;
        win_next_s  = win_cnt_r;
        vote_next_s = vote_cnt_r;
        min_next_s  = min_r;
        to_next_s   = to_flag_r;
        case (state_r)
            ST_IDLE: begin
                if (req && !abort) begin
                    fsm_next_s  = ST_START;
                    win_next_s  = 4'd0;
                    vote_next_s = 4'd0;
                    min_next_s  = MIN_INIT;
                    to_next_s   = 1'b0;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_START: fsm_next_s = ST_WAIT;
            ST_WAIT: begin
                if (judge_dready) begin
                    win_next_s = win_cnt_r + 4'd1;
                    if (judge_is_square) begin
                        vote_next_s = vote_cnt_r + 4'd1;
                        min_next_s  = (judge_min_width < min_r) ? judge_min_width : min_r;
                    end else begin
                        vote_next_s = vote_cnt_r;
                    end
                    fsm_next_s = (win_next_s == VOTE_NUM_C) ? ST_DONE : ST_GAP;
                end else if (timer_term_s) begin
                    to_next_s  = 1'b1;
                    fsm_next_s = ST_DONE;
                end else begin
                    fsm_next_s = ST_WAIT;
                end
            end
            ST_GAP:  fsm_next_s = timer_term_s ? ST_START : ST_GAP;
            ST_DONE: fsm_next_s = ST_IDLE;
            default: fsm_next_s = ST_IDLE;
        endcase
        state_next_s = abort ? ST_IDLE : fsm_next_s;
    end

    // Internal state and window accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            win_cnt_r  <= 4'd0;
            vote_cnt_r <= 4'd0;
            min_r      <= MIN_INIT;
            to_flag_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            win_cnt_r  <= win_next_s;
            vote_cnt_r <= vote_next_s;
            min_r      <= min_next_s;
            to_flag_r  <= to_next_s;
        end
    end

    // Outputs are registered from the next state so they line up with it;
    // results latch only on entry to DONE, so abort leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r             <= 1'b0;
            judge_start_r      <= 1'b0;
            result_valid_r     <= 1'b0;
            result_square_r    <= 1'b0;
            result_min_width_r <= MIN_INIT;
            result_votes_r     <= 4'd0;
            err_timeout_r      <= 1'b0;
        end else begin
            busy_r         <= (state_next_s != ST_IDLE);
            judge_start_r  <= (state_next_s == ST_START);
            result_valid_r <= (state_next_s == ST_DONE);
            if (state_next_s == ST_DONE) begin
                result_square_r    <= majority(vote_next_s, VOTE_NUM_C) && !to_next_s;
                result_min_width_r <= min_next_s;
                result_votes_r     <= vote_next_s;
                err_timeout_r      <= to_next_s;
            end else begin
                result_square_r    <= result_square_r;
                result_min_width_r <= result_min_width_r;
                result_votes_r     <= result_votes_r;
                err_timeout_r      <= err_timeout_r;
            end
        end
    end

    assign busy             = busy_r;
    assign judge_start      = judge_start_r;
    assign result_valid     = result_valid_r;
    assign result_square    = result_square_r;
    assign result_min_width = result_min_width_r;
    assign result_votes     = result_votes_r;
    assign err_timeout      = err_timeout_r;

endmodule

// File: tb/tb_square_judge_sched.sv
// Directed bench for square_judge_sched: a judge BFM per DUT instance, one
// instance with a 16-cycle gap and one with a zero gap and two windows.
module tb_square_judge_sched;

    localparam int W   = 18;
    localparam int VN  = 5;
    localparam int GAP = 16;
    localparam int TO  = 40;
    localparam int DLY = 12;
    localparam int MINI = 32'h3FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, req = 1'b0, abort = 1'b0, b_req = 1'b0;

    logic         a_busy, a_start, a_valid, a_sq, a_err;
    logic         a_dready = 1'b0, a_issq = 1'b0;
    logic [W-1:0] a_wid = '0, a_minw;
    logic [3:0]   a_votes;

    logic         b_busy, b_start, b_valid, b_sq, b_err;
    logic         b_dready = 1'b0, b_issq = 1'b0;
    logic [W-1:0] b_wid = '0, b_minw;
    logic [3:0]   b_votes;

    int vectors = 0, miscompares = 0;
    int cyc = 0;

    logic         pat_sq [0:4];
    int           pat_w  [0:4];
    logic         bfm_on = 1'b1, spur_on = 1'b0;
    int           a_base = 0;

    int a_starts = 0, a_nvalid = 0, a_cnt = 0, a_widx = 0, a_spur = 0;
    int a_dr_cyc = 0, a_start_cyc = 0, a_valid_cyc = 0;
    logic a_pend = 1'b0, a_have_dr = 1'b0;

    int b_starts = 0, b_nvalid = 0, b_cnt = 0, b_widx = 0, b_dr_cyc = 0;
    logic b_pend = 1'b0, b_have_dr = 1'b0;

    square_judge_sched #(.WIDTH_W(W), .VOTE_NUM(VN), .GAP_CYCLES(GAP), .TIMEOUT(TO), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .abort(abort), .busy(a_busy),
        .judge_start(a_start), .judge_dready(a_dready), .judge_is_square(a_issq),
        .judge_min_width(a_wid), .result_valid(a_valid), .result_square(a_sq),
        .result_min_width(a_minw), .result_votes(a_votes), .err_timeout(a_err)
    );

    square_judge_sched #(.WIDTH_W(W), .VOTE_NUM(2), .GAP_CYCLES(0), .TIMEOUT(TO), .CNT_W(32)) u_dut_gap0 (
        .clk(clk), .rst_n(rst_n), .req(b_req), .abort(1'b0), .busy(b_busy),
        .judge_start(b_start), .judge_dready(b_dready), .judge_is_square(b_issq),
        .judge_min_width(b_wid), .result_valid(b_valid), .result_square(b_sq),
        .result_min_width(b_minw), .result_votes(b_votes), .err_timeout(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Judge BFM and monitor for the main instance, evaluated mid-cycle.
    always @(negedge clk) begin
        if (a_dready) a_dready = 1'b0;
        if (a_start) begin
            if (a_have_dr) check("gap_spacing", 32'(cyc - a_dr_cyc), 32'(GAP + 2));
            a_have_dr   = 1'b0;
            a_widx      = a_starts - a_base;
            a_starts    = a_starts + 1;
            a_start_cyc = cyc;
            a_pend      = bfm_on;
            a_cnt       = DLY;
        end else if (a_pend) begin
            a_cnt = a_cnt - 1;
            if (a_cnt == 0) begin
                a_pend    = 1'b0;
                a_dready  = 1'b1;
                a_issq    = pat_sq[a_widx];
                a_wid     = W'(pat_w[a_widx]);
                a_dr_cyc  = cyc;
                a_have_dr = 1'b1;
                if (spur_on && a_widx == 1) a_spur = 5;
            end
        end
        if (a_spur > 0) begin
            a_spur = a_spur - 1;
            if (a_spur == 0) begin
                a_dready = 1'b1;
                a_issq   = 1'b1;
                a_wid    = W'(1);
            end
        end
        if (a_valid) begin
            a_nvalid    = a_nvalid + 1;
            a_valid_cyc = cyc;
        end
        if (!a_busy) a_have_dr = 1'b0;
    end

    // Judge BFM and monitor for the zero-gap instance.
    always @(negedge clk) begin
        if (b_dready) b_dready = 1'b0;
        if (b_start) begin
            if (b_have_dr) check("gap0_spacing", 32'(cyc - b_dr_cyc), 32'd2);
            b_have_dr = 1'b0;
            b_pend    = 1'b1;
            b_cnt     = DLY;
            b_widx    = b_starts;
            b_starts  = b_starts + 1;
        end else if (b_pend) begin
            b_cnt = b_cnt - 1;
            if (b_cnt == 0) begin
                b_pend    = 1'b0;
                b_dready  = 1'b1;
                b_issq    = 1'b1;
                b_wid     = (b_widx == 0) ? W'(100) : W'(70);
                b_dr_cyc  = cyc;
                b_have_dr = 1'b1;
            end
        end
        if (b_valid) b_nvalid = b_nvalid + 1;
    end

    task automatic load(input logic [4:0] sq, input int w0, input int w1, input int w2,
                        input int w3, input int w4);
        for (int i = 0; i < 5; i++) pat_sq[i] = sq[i];
        pat_w[0] = w0; pat_w[1] = w1; pat_w[2] = w2; pat_w[3] = w3; pat_w[4] = w4;
    endtask

    task automatic run_check(input string tag, input bit lat, input int extra, input logic e_sq,
                             input int e_votes, input int e_min, input logic e_err, input int e_starts);
        int s0, v0, n;
        s0 = a_starts;
        v0 = a_nvalid;
        a_base = a_starts;
        @(negedge clk);
        req = 1'b1;
        if (lat) begin
            #1;
            check({tag, "_start_before"}, 32'(a_start), 32'd0);
            check({tag, "_busy_before"}, 32'(a_busy), 32'd0);
            @(posedge clk);
            #1;
            check({tag, "_start_lat1"}, 32'(a_start), 32'd1);
            check({tag, "_busy_lat1"}, 32'(a_busy), 32'd1);
        end
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (a_nvalid == v0 && n < 600) begin
            @(negedge clk);
            #1;
            req = (n == extra);
            n++;
        end
        req = 1'b0;
        check({tag, "_valid_seen"}, 32'(a_nvalid != v0), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_valid_count"}, 32'(a_nvalid - v0), 32'd1);
        check({tag, "_starts"}, 32'(a_starts - s0), 32'(e_starts));
        check({tag, "_square"}, 32'(a_sq), 32'(e_sq));
        check({tag, "_votes"}, 32'(a_votes), 32'(e_votes));
        check({tag, "_min_width"}, 32'(a_minw), 32'(e_min));
        check({tag, "_err"}, 32'(a_err), 32'(e_err));
        check({tag, "_busy_after"}, 32'(a_busy), 32'd0);
    endtask

    initial begin
        int n, v0, s0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_start", 32'(a_start), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_min_width", 32'(a_minw), 32'(MINI));
        check("rst_votes", 32'(a_votes), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 32'(a_starts), 32'd0);

        load(5'b01011, 40, 25, 10, 30, 5);
        run_check("maj_pass", 1'b1, -1, 1'b1, 3, 25, 1'b0, 5);

        load(5'b00011, 40, 25, 7, 3, 1);
        run_check("maj_fail", 1'b0, -1, 1'b0, 2, 25, 1'b0, 5);

        load(5'b00000, 40, 25, 10, 30, 5);
        run_check("no_square", 1'b0, -1, 1'b0, 0, MINI, 1'b0, 5);

        bfm_on = 1'b0;
        run_check("timeout", 1'b0, -1, 1'b0, 0, MINI, 1'b1, 1);
        check("timeout_latency", 32'(a_valid_cyc - (a_start_cyc + 1)), 32'(TO));
        bfm_on = 1'b1;

        // Abort in the WAIT of the third window.
        load(5'b11111, 9, 8, 7, 6, 5);
        a_base = a_starts;
        s0 = a_starts;
        v0 = a_nvalid;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 0;
        while (a_starts - s0 < 3 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reached_w3", 32'(a_starts - s0), 32'd3);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_busy", 32'(a_busy), 32'd0);
        repeat (40) @(negedge clk);
        #1;
        check("abort_no_valid", 32'(a_nvalid - v0), 32'd0);
        check("abort_err_kept", 32'(a_err), 32'd1);
        check("abort_votes_kept", 32'(a_votes), 32'd0);
        check("abort_min_kept", 32'(a_minw), 32'(MINI));
        check("abort_no_more_starts", 32'(a_starts - s0), 32'd3);

        // Fresh run after abort, with a req while busy and a dready in GAP.
        spur_on = 1'b1;
        load(5'b10101, 50, 4, 60, 2, 45);
        run_check("after_abort", 1'b0, 50, 1'b1, 3, 45, 1'b0, 5);
        spur_on = 1'b0;

        // Zero-gap, two-window instance.
        v0 = b_nvalid;
        @(negedge clk); b_req = 1'b1;
        @(negedge clk); b_req = 1'b0;
        n = 0;
        while (b_nvalid == v0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("gap0_valid_seen", 32'(b_nvalid - v0), 32'd1);
        check("gap0_starts", 32'(b_starts), 32'd2);
        check("gap0_square", 32'(b_sq), 32'd1);
        check("gap0_votes", 32'(b_votes), 32'd2);
        check("gap0_min_width", 32'(b_minw), 32'd70);

        // Asynchronous reset in the middle of a WAIT.
        load(5'b11111, 3, 3, 3, 3, 3);
        a_base = a_starts;
        s0 = a_starts;
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 0;
        while (a_starts == s0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(a_busy), 32'd0);
        check("arst_square", 32'(a_sq), 32'd0);
        check("arst_votes", 32'(a_votes), 32'd0);
        check("arst_min_width", 32'(a_minw), 32'(MINI));
        @(negedge clk);
        rst_n = 1'b1;
        s0 = a_starts;
        repeat (40) @(negedge clk);
        #1;
        check("arst_no_restart", 32'(a_starts - s0), 32'd0);
        check("arst_idle", 32'(a_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
